// File: rtl/mb_tx_flit_sched.sv
// mb_tx_flit_sched: round-robin scheduler for two requesters that serializes
// 512-bit flits onto a 16-lane mainband, 4 bursts of 8 UI per flit.
module mb_tx_flit_sched #(
    parameter int GAP_CYCLES = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid_i,
    input  logic [511:0] req0_data_i,
    output logic         req0_ready_o,
    input  logic         req1_valid_i,
    input  logic [511:0] req1_data_i,
    output logic         req1_ready_o,
    output logic         valid_o,
    output logic [15:0]  data_o,
    output logic         busy_o,
    output logic [1:0]   grant_o,
    output logic [15:0]  flits_sent_o
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    state_e       state_q, state_d;
    logic [4:0]   ui_cnt_q, ui_cnt_d;
    logic [3:0]   gap_cnt_q, gap_cnt_d;
    logic         last_grant_q, last_grant_d;
    logic [511:0] flit_q, flit_d;
    logic [15:0]  flits_sent_q, flits_sent_d;
    logic         valid_q, valid_d, busy_q, busy_d;
    logic [15:0]  data_q, data_d;
    logic [1:0]   grant_q, grant_d;
    logic         can_accept, xfer, win;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ui_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            flits_sent_q <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            ui_cnt_q     <= ui_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            flits_sent_q <= flits_sent_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
        end
    end
    always_ff @(posedge clk) flit_q <= flit_d;
    always_comb begin
        can_accept   = state_q == IDLE || (state_q == SEND && ui_cnt_q == 5'd31 && GAP_CYCLES == 0);
        req0_ready_o = can_accept && req0_valid_i && (!req1_valid_i || last_grant_q);
        req1_ready_o = can_accept && req1_valid_i && (!req0_valid_i || !last_grant_q);
        xfer         = req0_ready_o || req1_ready_o;
        win          = req1_ready_o;
        last_grant_d = xfer ? win : last_grant_q;
        flit_d       = xfer ? (win ? req1_data_i : req0_data_i) : flit_q;
        ui_cnt_d     = xfer ? 5'd0 : (state_q == SEND ? ui_cnt_q + 5'd1 : ui_cnt_q);
        gap_cnt_d    = state_q == GAP ? gap_cnt_q + 4'd1 : 4'd0;
        flits_sent_d = flits_sent_q + 16'(state_q == SEND && ui_cnt_q == 5'd31);
        case (state_q)
            IDLE:    state_d = xfer ? SEND : IDLE;
            SEND:    state_d = ui_cnt_q != 5'd31 ? SEND : GAP_CYCLES > 0 ? GAP : xfer ? SEND : IDLE;
            GAP:     state_d = gap_cnt_q == GAP_LAST ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end
    // Lane values are computed from next-state so the registered outputs show UI 0 right after transfer
    always_comb begin
        valid_d = state_d == SEND && !ui_cnt_d[2];
        busy_d  = state_d != IDLE;
        grant_d = state_d != SEND ? 2'b00 : xfer ? (win ? 2'b10 : 2'b01) : grant_q;
        data_d  = '0;
        for (int j = 0; j < 16; j++)
            data_d[j] = state_d == SEND && flit_d[{ui_cnt_d[4:3], 4'(j), ui_cnt_d[2:0]}];
    end
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign busy_o       = busy_q;
    assign grant_o      = grant_q;
    assign flits_sent_o = flits_sent_q;
endmodule

// File: tb/tb_mb_tx_flit_sched.sv
// tb_mb_tx_flit_sched: two schedulers (no gap and a 3-cycle gap) share one set of
// requesters; a per-cycle flit-timeline model plus literal checks judge both.
module tb_mb_tx_flit_sched;
    logic         clk = 1'b0, reset = 1'b1;
    logic         r0v = 1'b0, r1v = 1'b0;
    logic [511:0] r0d = '0, r1d = '0;
    logic         rdy0 [2], rdy1 [2], vo [2], bo [2];
    logic [15:0]  dat [2], fs [2];
    logic [1:0]   gr [2];
    int           checks = 0, failures = 0, cyc = 0;
    int           has [2], lastc [2], src [2], mlast [2], mflits [2];
    logic [511:0] mf [2];
    bit           armed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mb_tx_flit_sched #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req0_valid_i(r0v), .req0_data_i(r0d), .req0_ready_o(rdy0[0]),
        .req1_valid_i(r1v), .req1_data_i(r1d), .req1_ready_o(rdy1[0]),
        .valid_o(vo[0]), .data_o(dat[0]), .busy_o(bo[0]), .grant_o(gr[0]), .flits_sent_o(fs[0])
    );
    mb_tx_flit_sched #(.GAP_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid_i(r0v), .req0_data_i(r0d), .req0_ready_o(rdy0[1]),
        .req1_valid_i(r1v), .req1_data_i(r1d), .req1_ready_o(rdy1[1]),
        .valid_o(vo[1]), .data_o(dat[1]), .busy_o(bo[1]), .grant_o(gr[1]), .flits_sent_o(fs[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: the latest transfer cycle fixes the whole timeline that follows it.
    task automatic model_step(input int g);
        int gap, d, u;
        bit can, e0, e1, ev, eb;
        logic [15:0] ed;
        logic [1:0] eg;
        gap = g ? 3 : 0;
        d = cyc - lastc[g];
        ev = 0; eb = 0; ed = '0; eg = '0;
        if (has[g] != 0 && d >= 1 && d <= 32) begin
            u = d - 1;
            ev = (u % 8) < 4;
            eb = 1;
            eg = src[g] != 0 ? 2'b10 : 2'b01;
            for (int j = 0; j < 16; j++) ed[j] = mf[g][(16 * (u / 8) + j) * 8 + u % 8];
        end else if (has[g] != 0 && d >= 33 && d <= 32 + gap) eb = 1;
        can = has[g] == 0 || d >= 33 + gap || (gap == 0 && d == 32);
        e0 = can && r0v && (!r1v || mlast[g] == 1);
        e1 = can && r1v && (!r0v || mlast[g] == 0);
        chk($sformatf("dut%0d ready0", g), 64'(rdy0[g]), 64'(e0));
        chk($sformatf("dut%0d ready1", g), 64'(rdy1[g]), 64'(e1));
        chk($sformatf("dut%0d valid", g), 64'(vo[g]), 64'(ev));
        chk($sformatf("dut%0d data", g), 64'(dat[g]), 64'(ed));
        chk($sformatf("dut%0d busy", g), 64'(bo[g]), 64'(eb));
        chk($sformatf("dut%0d grant", g), 64'(gr[g]), 64'(eg));
        chk($sformatf("dut%0d flits", g), 64'(fs[g]), 64'(mflits[g] & 32'hFFFF));
        if (has[g] != 0 && d == 32) mflits[g]++;
        if (e0 || e1) begin
            has[g] = 1; lastc[g] = cyc; src[g] = e1; mlast[g] = e1;
            mf[g] = e1 ? r1d : r0d;
        end
    endtask

    always @(negedge clk) begin
        if (armed) for (int g = 0; g < 2; g++) model_step(g);
        if (reset) begin
            for (int g = 0; g < 2; g++) begin
                has[g] = 0; mflits[g] = 0; mlast[g] = 1;
            end
            armed = 1;
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask
    task automatic at(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int c, c2;
        logic [15:0] pat [8];
        pat = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        repeat (2) drive();
        reset = 0;
        // single flit from requester 0
        drive(); r0v = 1; r0d = '0; r0d[7:0] = 8'hFF; r0d[71:64] = 8'hFE; c = cyc;
        at(c);
        chk("single ready0", 64'(rdy0[0]), 1);
        drive(); r0v = 0;
        at(c + 1);
        chk("single ready0 low", 64'(rdy0[0]), 0);
        chk("single valid ui0", 64'(vo[0]), 1);
        chk("single data ui0", 64'(dat[0]), 64'h0001);
        chk("single grant", 64'(gr[0]), 64'b01);
        at(c + 2); chk("single data ui1", 64'(dat[0]), 64'h0101);
        at(c + 5); chk("single valid ui4", 64'(vo[0]), 0);
        at(c + 8); chk("single valid ui7", 64'(vo[0]), 0);
        at(c + 32); chk("single busy ui31", 64'(bo[0]), 1);
        at(c + 33);
        chk("single flits", 64'(fs[0]), 1);
        chk("single busy end", 64'(bo[0]), 0);
        chk("gap3 busy in gap", 64'(bo[1]), 1);
        chk("gap3 valid in gap", 64'(vo[1]), 0);
        // lane mapping with all bytes 0xA5
        at(c + 40); drive(); r0v = 1; r0d = {64{8'hA5}}; c = cyc;
        at(c); chk("a5 ready0", 64'(rdy0[0]), 1);
        drive(); r0v = 0;
        for (int u = 0; u < 32; u++) begin
            at(c + 1 + u);
            chk($sformatf("a5 data ui%0d", u), 64'(dat[0]), 64'(pat[u % 8]));
            chk($sformatf("a5 valid ui%0d", u), 64'(vo[0]), 64'((u % 8) < 4));
        end
        // both requesters valid continuously, starting from a fresh reset
        at(c + 40); drive(); reset = 1; drive(); reset = 0;
        r0v = 1; r1v = 1; r0d = {8{64'h0123456789ABCDEF}}; r1d = {16{32'hDEADBEEF}}; c = cyc;
        at(c);
        chk("rr first tie ready0", 64'(rdy0[0]), 1);
        chk("rr first tie ready1", 64'(rdy1[0]), 0);
        at(c + 1); chk("rr grant 1st", 64'(gr[0]), 64'b01);
        at(c + 32);
        chk("rr b2b ready1", 64'(rdy1[0]), 1);
        chk("rr busy ui31", 64'(bo[0]), 1);
        at(c + 33);
        chk("rr grant 2nd", 64'(gr[0]), 64'b10);
        chk("rr no bubble", 64'(vo[0]), 1);
        at(c + 65); chk("rr grant 3rd", 64'(gr[0]), 64'b01);
        at(c + 97); chk("rr grant 4th", 64'(gr[0]), 64'b10);
        at(c + 129); chk("rr flits 4", 64'(fs[0]), 4);
        drive(); r0v = 0; r1v = 0;
        // gap of 3 with requester 1 valid continuously
        at(c + 170); drive(); reset = 1; drive(); reset = 0;
        r1v = 1; r1d = {32{16'h3C96}}; c = cyc;
        at(c); chk("gap ready1 first", 64'(rdy1[1]), 1);
        for (int k = 33; k <= 35; k++) begin
            at(c + k);
            chk($sformatf("gap busy +%0d", k), 64'(bo[1]), 1);
            chk($sformatf("gap valid +%0d", k), 64'(vo[1]), 0);
            chk($sformatf("gap ready +%0d", k), 64'(rdy1[1]), 0);
        end
        at(c + 36);
        chk("gap end busy", 64'(bo[1]), 0);
        chk("gap end ready1", 64'(rdy1[1]), 1);
        at(c + 37);
        chk("gap next valid", 64'(vo[1]), 1);
        chk("gap next grant", 64'(gr[1]), 64'b10);
        at(c + 40); drive(); r1v = 0;
        // reset in the middle of a flit
        at(c + 80); drive(); reset = 1; drive(); reset = 0;
        r0v = 1; r0d = {4{128'h00FF_1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA}}; c = cyc;
        drive(); r0v = 0;
        at(c + 10); drive(); reset = 1; drive(); reset = 0;
        at(c + 12);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("abort dut%0d valid", g), 64'(vo[g]), 0);
            chk($sformatf("abort dut%0d data", g), 64'(dat[g]), 0);
            chk($sformatf("abort dut%0d busy", g), 64'(bo[g]), 0);
            chk($sformatf("abort dut%0d grant", g), 64'(gr[g]), 0);
            chk($sformatf("abort dut%0d flits", g), 64'(fs[g]), 0);
        end
        drive(); r1v = 1; r1d = {64{8'h81}}; c2 = cyc;
        at(c2); chk("restart ready1", 64'(rdy1[0]), 1);
        drive(); r1v = 0;
        at(c2 + 1);
        chk("restart valid", 64'(vo[0]), 1);
        chk("restart grant", 64'(gr[0]), 64'b10);
        chk("restart data ui0", 64'(dat[0]), 64'hFFFF);
        at(c2 + 45);
        chk("restart flits", 64'(fs[0]), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mb_tx_flit_sched.md
MB_TX_FLIT_SCHED -- requirements
Module: mb_tx_flit_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 0: idle cycles inserted between consecutive flits (0 to 15).
REQ-002 clk  input  1  single block clock; all logic is on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid_i  input  1  requester 0 holds a flit.
REQ-005 req0_data_i  input  512  requester 0 flit; byte n = bits [8n+7:8n], n = 0..63.
REQ-006 req0_ready_o  output  1  requester 0 flit accepted this cycle.
REQ-007 req1_valid_i, req1_data_i, req1_ready_o: same as REQ-004 to REQ-006, for requester 1.
REQ-008 valid_o  output  1  mainband valid-lane value for the current UI.
REQ-009 data_o  output  16  mainband data-lane values for the current UI; bit j = lane j.
REQ-010 busy_o  output  1  a flit is being serialized or a gap is in progress.
REQ-011 grant_o  output  2  one-hot source of the flit in flight; 00 when idle.
REQ-012 flits_sent_o  output  16  count of completed flits; wraps from 0xFFFF to 0.

Function
REQ-013 States: IDLE, SEND, GAP; reset state is IDLE.
REQ-014 Transfer rule: a transfer occurs on a cycle where reqN_valid_i and reqN_ready_o are both 1; the 512-bit flit is captured into an internal register.
REQ-015 reqN_ready_o is combinational and asserts only when the scheduler can accept and requester N wins arbitration.
- At most one ready is high per cycle.
REQ-016 The scheduler can accept when:
- state is IDLE; or
- state is SEND, ui_cnt = 31 and GAP_CYCLES = 0.
REQ-017 Arbitration is round-robin via a last_grant register:
- Only one requester valid: that requester wins.
- Both valid: the requester not equal to last_grant wins.
- last_grant resets to requester 1, so requester 0 wins the first tie.
REQ-018 On transfer: state becomes SEND, ui_cnt = 0, grant_o = winner one-hot, last_grant = winner.
REQ-019 Latency: the first UI of a flit appears on the outputs one cycle after the transfer cycle.
REQ-020 A flit is 4 bursts of 8 UI, 32 SEND cycles in total. ui_cnt runs 0..31; burst k = ui_cnt[4:3], bit i = ui_cnt[2:0].
REQ-021 In SEND, data_o[j] = bit i of byte (16k + j), for j = 0..15.
REQ-022 In SEND, valid_o = 1 for i = 0..3 and 0 for i = 4..7 of every burst.
REQ-023 Outside SEND, valid_o = 0, data_o = 0 and grant_o = 00.
REQ-024 At ui_cnt = 31, flits_sent_o increments, then:
- if GAP_CYCLES > 0: go to GAP with gap_cnt = 0;
- else if a transfer occurs in that cycle: restart SEND at ui_cnt = 0 (no bubble between flits);
- else: go to IDLE.
REQ-025 GAP lasts exactly GAP_CYCLES cycles, then IDLE. No ready is asserted during GAP.
REQ-026 busy_o = 1 in SEND and GAP, 0 in IDLE.
REQ-027 A requester's valid_i dropping while not granted has no effect. Captured data is not affected by later input changes.
REQ-028 All outputs are registered except reqN_ready_o.

Reset
REQ-029 Reset takes effect at the next rising clk edge and overrides every other event, including a transfer in the same cycle.
REQ-030 After reset: state IDLE, ui_cnt 0, gap_cnt 0, last_grant = 1.
- Outputs: valid_o 0, data_o 0, busy_o 0, grant_o 00, flits_sent_o 0.
- reqN_ready_o reflects the IDLE state in the first cycle after reset is released.
REQ-031 Reset during SEND aborts the flit: there is no further lane activity and flits_sent_o is not incremented.

Verification
REQ-032 Single flit from requester 0, with byte0 = 0xFF, byte8 = 0xFE, bytes 1..7 and 9..15 = 0x00:
- Required: req0_ready_o high for 1 cycle.
- Cycle +1: valid_o = 1, data_o = 0x0001 (byte8 bit0 = 0).
- Cycle +2: data_o = 0x0101.
- Cycles +5..+8: valid_o = 0.
- After 32 cycles: flits_sent_o = 1, busy_o = 0.
REQ-033 Lane mapping: flit with all 64 bytes = 0xA5, GAP_CYCLES = 0.
- Required: data_o alternates 0xFFFF, 0x0000, 0xFFFF, 0x0000, 0x0000, 0xFFFF, 0x0000, 0xFFFF across each 8-UI burst.
- valid_o pattern across each burst is 1,1,1,1,0,0,0,0.
REQ-034 Both requesters valid continuously, GAP_CYCLES = 0:
- Grants alternate 0,1,0,1.
- Flits are back-to-back with no idle cycle.
- flits_sent_o = 4 after 128 SEND cycles.
REQ-035 GAP_CYCLES = 3, requester 1 valid continuously: each flit is separated by exactly 3 cycles with busy_o = 1, valid_o = 0 and ready = 0.
REQ-036 Reset asserted at ui_cnt = 10:
- Next cycle: all outputs are at reset values and flits_sent_o is unchanged from its pre-flit value.
- A new flit starts cleanly afterwards.
